// File: rtl/seq_pattern_pkg.sv
// Shared constants and state encoding for the sequence pattern generator/detector pair.
package seq_pattern_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      GAP    = 2'd2,
      FINISH = 2'd3
   } seq_state_e;

   localparam int         SEQ_PATTERN_DEFAULT_LEN = 6;
   localparam logic [5:0] SEQ_PATTERN_DEFAULT     = 6'b110101;

endpackage

// File: rtl/sequence_pattern_shifter.sv
// Loadable MSB-first shift register with a saturating bit index and last-bit flag.
module sequence_pattern_shifter
   import seq_pattern_pkg::*;
#(
   parameter int               LEN = SEQ_PATTERN_DEFAULT_LEN,
   parameter logic [LEN-1:0]   PAT = LEN'(SEQ_PATTERN_DEFAULT)
) (
   input  logic clk,
   input  logic rest,
   input  logic load,
   input  logic shift,
   output logic msb_next,
   output logic last_bit
);

   localparam int             IW       = $clog2(LEN);
   localparam logic [IW-1:0]  IDX_LAST = IW'(LEN - 1);

   logic [LEN-1:0] sreg_q, sreg_d;
   logic [IW-1:0]  idx_q, idx_d;

   always_comb begin
      sreg_d = sreg_q;
      idx_d  = idx_q;
      if (load) begin
         sreg_d = PAT;
         idx_d  = '0;
      end else if (shift) begin
         sreg_d = {sreg_q[LEN-2:0], 1'b0};
         if (idx_q != IDX_LAST) idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         sreg_q <= '0;
         idx_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         idx_q  <= idx_d;
      end
   end

   // Outputs in the top are registered, so they need the post-edge MSB.
   assign msb_next = sreg_d[LEN-1];
   assign last_bit = (idx_q == IDX_LAST);

endmodule

// File: rtl/sequence_pattern_generator.sv
// Serial pattern transmitter: repeats PATTERN count times with GAP_LEN idle cycles between bursts.
// Optional abort input enabled by defining SEQ_PATTERN_GEN_ABORT_EN.
module sequence_pattern_generator
   import seq_pattern_pkg::*;
#(
   parameter int                     PATTERN_LEN = SEQ_PATTERN_DEFAULT_LEN,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(SEQ_PATTERN_DEFAULT),
   parameter int                     GAP_LEN     = 2
) (
   input  logic       clk,
   input  logic       rest,
   input  logic       start,
   input  logic [7:0] count,
`ifdef SEQ_PATTERN_GEN_ABORT_EN
   input  logic       abort,
`endif
   output logic       out,
   output logic       out_valid,
   output logic       busy,
   output logic       done
);

   localparam int            GW       = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   seq_state_e    state_q, state_d;
   logic [7:0]    rep_q, rep_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          out_q, out_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          load, shift, msb_next, last_bit;
   logic          abort_req;

`ifdef SEQ_PATTERN_GEN_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   sequence_pattern_shifter #(
      .LEN (PATTERN_LEN),
      .PAT (PATTERN)
   ) u_shifter (
      .clk      (clk),
      .rest     (rest),
      .load     (load),
      .shift    (shift),
      .msb_next (msb_next),
      .last_bit (last_bit)
   );

   always_comb begin
      state_d = state_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (count != 8'd0) begin
                  rep_d   = count;
                  gap_d   = '0;
                  load    = 1'b1;
                  state_d = SHIFT;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         SHIFT: begin
            if (abort_req) begin
               state_d = FINISH;
            end else if (last_bit) begin
               rep_d = rep_q - 8'd1;
               if (rep_q == 8'd1) begin
                  state_d = FINISH;
               end else if (GAP_LEN == 0) begin
                  load  = 1'b1;
                  gap_d = '0;
               end else begin
                  gap_d   = '0;
                  state_d = GAP;
               end
            end else begin
               shift = 1'b1;
            end
         end
         GAP: begin
            if (abort_req) begin
               state_d = FINISH;
            end else if (gap_q == GAP_LAST) begin
               load    = 1'b1;
               gap_d   = '0;
               state_d = SHIFT;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs decode the next state so they line up with it after the edge.
      out_valid_d = (state_d == SHIFT);
      out_d       = out_valid_d & msb_next;
      busy_d      = (state_d == SHIFT) || (state_d == GAP);
      done_d      = (state_d == FINISH);
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q     <= IDLE;
         rep_q       <= '0;
         gap_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rep_q       <= rep_d;
         gap_q       <= gap_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Scoreboard bench for sequence_pattern_generator with default parameters (110101, gap 2).
module tb_sequence_pattern_generator;

   localparam int L = 6;
   localparam int G = 2;

   typedef struct {
      bit is_done;
      bit b;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rest = 1'b0;
   logic       start = 1'b0;
   logic [7:0] count = 8'd0;
   logic       abort = 1'b0;
   logic       out, out_valid, busy, done;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   busy_lo = 0;
   int   busy_hi = -1;
   int   valid_cnt = 0;
   logic [5:0] pat_v = 6'b110101;

   sequence_pattern_generator dut (
      .clk       (clk),
      .rest      (rest),
      .start     (start),
      .count     (count),
`ifdef SEQ_PATTERN_GEN_ABORT_EN
      .abort     (abort),
`endif
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation for every valid bit or done pulse.
   always @(negedge clk) begin
      if (!rest) begin
         if (out_valid || done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: cycle %0d out_valid=%0b done=%0b, expected no output",
                        cyc, out_valid, done);
            end else begin
               mon_e = sb_q.pop_front();
               check("event_kind", int'(done), int'(mon_e.is_done));
               check("event_cycle", cyc, mon_e.cyc);
               if (!mon_e.is_done) check("out_bit", int'(out), int'(mon_e.b));
            end
         end
         if (out_valid) valid_cnt++;
         else check("out_zero_when_invalid", int'(out), 0);
         check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      end
   end

   function automatic int done_offset(input int c);
      return (c == 0) ? 0 : c * L + (c - 1) * G;
   endfunction

   task automatic push_tx(input int k, input int c);
      exp_t e;
      for (int r = 0; r < c; r++) begin
         for (int i = 0; i < L; i++) begin
            e.is_done = 1'b0;
            e.b       = pat_v[L-1-i];
            e.cyc     = k + r * (L + G) + i;
            sb_q.push_back(e);
         end
      end
      e.is_done = 1'b1;
      e.b       = 1'b0;
      e.cyc     = k + done_offset(c);
      sb_q.push_back(e);
      busy_lo = k;
      busy_hi = k + done_offset(c) - 1;
   endtask

   // Issues start with count c; returns at the negedge of acceptance cycle k.
   task automatic tx_start(input int c, input bit push, output int k);
      @(negedge clk);
      start     = 1'b1;
      count     = 8'(c);
      valid_cnt = 0;
      @(posedge clk);
      #1;
      k = cyc;
      if (push) push_tx(k, c);
      @(negedge clk);
      start = 1'b0;
      count = 8'hA5;
   endtask

   task automatic run_tx(input int c, input string name);
      int k;
      tx_start(c, 1'b1, k);
      repeat (done_offset(c) + 2) @(negedge clk);
      check({name, "_queue_empty"}, sb_q.size(), 0);
      check({name, "_valid_bits"}, valid_cnt, c * L);
   endtask

   initial begin
      int k;
      exp_t e;
      #2 rest = 1'b1;
      #1;
      check("reset_out", int'(out), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      @(negedge clk);
      rest = 1'b0;
      repeat (2) @(negedge clk);

      run_tx(1, "count1");
      run_tx(3, "count3");
      run_tx(0, "count0");

      // Re-pulsed start during bit 3 must be ignored.
      tx_start(2, 1'b1, k);
      repeat (3) @(negedge clk);
      start = 1'b1;
      count = 8'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (done_offset(2) - 2) @(negedge clk);
      check("repulse_queue_empty", sb_q.size(), 0);
      check("repulse_valid_bits", valid_cnt, 12);

      // Reset during bit 4: everything clears, no done.
      tx_start(1, 1'b1, k);
      repeat (4) @(negedge clk);
      #2 rest = 1'b1;
      #1;
      check("midrst_out", int'(out), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_valid_bits", valid_cnt, 5);
      sb_q.delete();
      busy_hi = busy_lo - 1;
      @(negedge clk);
      rest = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_no_late_output", sb_q.size(), 0);
      run_tx(1, "after_reset");

`ifdef SEQ_PATTERN_GEN_ABORT_EN
      // Abort in the first gap of a count=4 run.
      tx_start(4, 1'b0, k);
      for (int i = 0; i < L; i++) begin
         e.is_done = 1'b0;
         e.b       = pat_v[L-1-i];
         e.cyc     = k + i;
         sb_q.push_back(e);
      end
      e.is_done = 1'b1;
      e.b       = 1'b0;
      e.cyc     = k + L + 1;
      sb_q.push_back(e);
      busy_lo = k;
      busy_hi = k + L;
      repeat (L) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_queue_empty", sb_q.size(), 0);
      check("abort_valid_bits", valid_cnt, L);
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
